// File: rtl/seq_comb_monitor.sv
// Purpose: drives lanes through assign/always_comb copies and counts sampled 4-state disagreements over a window.
// Latency: copies zero-latency, first compare one cycle after entering RUN; no backpressure, start/ack ignored outside IDLE/DONE.
module seq_comb_monitor #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int WINDOW   = 16,
  parameter int CNT_W    = 8,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      ack,
  input  logic [CHANNELS*WIDTH-1:0] a,
  output logic [CHANNELS*WIDTH-1:0] out_cont,
  output logic [CHANNELS*WIDTH-1:0] out_proc,
  output logic                      busy,
  output logic                      done,
  output logic [CNT_W-1:0]          mismatch_cnt,
  output logic                      first_valid,
  output logic [CH_W-1:0]           first_ch
);

  localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                    state_q, state_d;
  logic [WIN_W-1:0]          win_q;
  logic                      primed_q;
  logic [CHANNELS*WIDTH-1:0] samp_c, samp_p;
  logic [CHANNELS-1:0]       lane_mis;
  logic                      any_mis;
  logic [CH_W-1:0]           low_ch;
  logic                      start_acc;
  logic                      last_cmp;

  assign out_cont = a;

  always_comb begin
    out_proc = a;
  end

  // Case-inequality so X/Z patterns only match when identical.
  always_comb begin
    lane_mis = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      lane_mis[i] = (samp_c[i*WIDTH +: WIDTH] !== samp_p[i*WIDTH +: WIDTH]);
    end
  end

  always_comb begin
    low_ch = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (lane_mis[i]) low_ch = CH_W'(i);
    end
  end

  assign any_mis  = |lane_mis;
  assign last_cmp = primed_q && (win_q == '0);

  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_d   = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_cmp) state_d = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      win_q        <= '0;
      primed_q     <= 1'b0;
      samp_c       <= '0;
      samp_p       <= '0;
      mismatch_cnt <= '0;
      first_valid  <= 1'b0;
      first_ch     <= '0;
    end else begin
      state_q <= state_d;
      if (start_acc) begin
        mismatch_cnt <= '0;
        first_valid  <= 1'b0;
        first_ch     <= '0;
        win_q        <= WIN_W'(WINDOW - 1);
        primed_q     <= 1'b0;
      end
      if (state_q == RUN) begin
        samp_c   <= out_cont;
        samp_p   <= out_proc;
        primed_q <= 1'b1;
        // The first RUN edge only fills the sample pair; compares start after.
        if (primed_q) begin
          if (any_mis && (mismatch_cnt != '1)) mismatch_cnt <= mismatch_cnt + 1'b1;
          if (any_mis && !first_valid) begin
            first_valid <= 1'b1;
            first_ch    <= low_ch;
          end
          if (win_q != '0) win_q <= win_q - 1'b1;
        end
      end
    end
  end

endmodule
